// File: rtl/multi_interval_timer.sv
// multi_interval_timer: NUM_CH prescaled down-counting interval timers behind one Avalon-MM slave.
// Define MULTI_TIMER_PULSE_OUT_EN to add the per-channel registered timeout_pulse output.
module multi_interval_timer #(
    parameter int          NUM_CH       = 2,
    parameter int          COUNT_W      = 32,
    parameter int          PRE_W        = 16,
    parameter logic [31:0] RESET_PERIOD = 32'h0007A11F,
    localparam int         ADDR_W       = 3 + $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
`ifdef MULTI_TIMER_PULSE_OUT_EN
    ,
    output logic [NUM_CH-1:0] timeout_pulse
`endif
);

    localparam logic [COUNT_W-1:0] RST_PERIOD = RESET_PERIOD[COUNT_W-1:0];

    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-1:0] w_ch;
    logic [2:0]        w_reg;
    logic [NUM_CH-1:0] w_to;
    logic [NUM_CH-1:0] w_irq_ch;
    logic [31:0]       w_rdat [NUM_CH];
    logic [31:0]       w_rd_mux;
    logic [31:0]       r_readdata;

    assign w_wr  = chipselect & ~write_n;
    assign w_rd  = chipselect & write_n;
    assign w_ch  = address >> 3;
    assign w_reg = address[2:0];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [COUNT_W-1:0] r_cnt;
        logic [COUNT_W-1:0] r_period;
        logic [COUNT_W-1:0] r_snap;
        logic [PRE_W-1:0]   r_pre;
        logic [PRE_W-1:0]   r_pc;
        logic               r_to;
        logic               r_run;
        logic               r_ito;
        logic               r_cont;
        logic               w_sel;
        logic               w_per_wr;
        logic               w_start;
        logic               w_stop;
        logic               w_tick;
        logic               w_tmo;
        logic [31:0]        w_rd_ch;

        assign w_sel    = w_wr && (w_ch == ADDR_W'(gi));
        assign w_per_wr = w_sel && (w_reg == 3'd2);
        assign w_start  = w_sel && (w_reg == 3'd1) && writedata[2];
        assign w_stop   = w_sel && (w_reg == 3'd1) && writedata[3];
        assign w_tick   = r_run && (r_pc == '0);
        assign w_tmo    = w_tick && (r_cnt == '0);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt    <= RST_PERIOD;
                r_period <= RST_PERIOD;
                r_snap   <= '0;
                r_pre    <= '0;
                r_pc     <= '0;
                r_to     <= 1'b0;
                r_run    <= 1'b0;
                r_ito    <= 1'b0;
                r_cont   <= 1'b0;
            end else begin
                if (w_sel && (w_reg == 3'd1)) begin
                    r_ito  <= writedata[0];
                    r_cont <= writedata[1];
                end
                if (w_per_wr)
                    r_period <= writedata[COUNT_W-1:0];
                if (w_sel && (w_reg == 3'd4))
                    r_pre <= writedata[PRE_W-1:0];
                if (w_sel && (w_reg == 3'd3))
                    r_snap <= r_cnt;

                // A PERIOD write force-loads the counter, overriding any tick this cycle.
                if (w_per_wr)
                    r_cnt <= writedata[COUNT_W-1:0];
                else if (w_tick)
                    r_cnt <= w_tmo ? r_period : r_cnt - COUNT_W'(1);

                if (w_per_wr || w_start || w_tick)
                    r_pc <= r_pre;
                else if (r_run)
                    r_pc <= r_pc - PRE_W'(1);

                if (w_per_wr)
                    r_run <= 1'b0;
                else if (w_start)
                    r_run <= 1'b1;
                else if (w_stop || (w_tmo && !r_cont))
                    r_run <= 1'b0;

                // Set beats a coincident clear so no timeout is lost.
                if (w_tmo)
                    r_to <= 1'b1;
                else if (w_sel && (w_reg == 3'd0))
                    r_to <= 1'b0;
            end
        end

        always_comb begin
            w_rd_ch = '0;
            case (w_reg)
                3'd0:    w_rd_ch[1:0]         = {r_run, r_to};
                3'd1:    w_rd_ch[1:0]         = {r_cont, r_ito};
                3'd2:    w_rd_ch[COUNT_W-1:0] = r_period;
                3'd3:    w_rd_ch[COUNT_W-1:0] = r_snap;
                3'd4:    w_rd_ch[PRE_W-1:0]   = r_pre;
                3'd5:    w_rd_ch[NUM_CH-1:0]  = w_to;
                default: w_rd_ch              = '0;
            endcase
        end

        assign w_rdat[gi]   = w_rd_ch;
        assign w_to[gi]     = r_to;
        assign w_irq_ch[gi] = r_to & r_ito;

`ifdef MULTI_TIMER_PULSE_OUT_EN
        logic r_pulse;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                r_pulse <= 1'b0;
            else
                r_pulse <= w_tmo;
        end

        assign timeout_pulse[gi] = r_pulse;
`endif
    end

    // Channel numbers beyond NUM_CH fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == ADDR_W'(i))
                w_rd_mux = w_rdat[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_readdata <= '0;
        else
            r_readdata <= w_rd ? w_rd_mux : '0;
    end

    assign readdata = r_readdata;
    assign irq      = |w_irq_ch;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Self-checking bench for multi_interval_timer: directed scenarios plus random bus traffic
// compared every cycle against a rule-level model of the channels.
module tb_multi_interval_timer;

    localparam int NCH = 3;
    localparam int AW  = 3 + $clog2(NCH);

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          cs      = 1'b0;
    logic          wn      = 1'b1;
    logic [AW-1:0] addr    = '0;
    logic [31:0]   wd      = '0;
    logic [31:0]   rdata;
    logic          irq;
`ifdef MULTI_TIMER_PULSE_OUT_EN
    logic [NCH-1:0] tpulse;
`endif

    always #5 clk = ~clk;

    multi_interval_timer #(
        .NUM_CH (NCH),
        .COUNT_W(32),
        .PRE_W  (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (addr),
        .chipselect(cs),
        .write_n   (wn),
        .writedata (wd),
        .readdata  (rdata),
        .irq       (irq)
`ifdef MULTI_TIMER_PULSE_OUT_EN
        ,
        .timeout_pulse(tpulse)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_cnt [NCH];
    logic [31:0] m_per [NCH];
    logic [31:0] m_pre [NCH];
    logic [31:0] m_pc  [NCH];
    logic [31:0] m_snap[NCH];
    bit          m_to  [NCH];
    bit          m_run [NCH];
    bit          m_ito [NCH];
    bit          m_cont[NCH];
    bit          m_pulse[NCH];
    logic [31:0] m_rd;

    function automatic logic [31:0] m_read(input int ch, input int r);
        logic [31:0] v;
        v = 32'd0;
        if (ch >= NCH) return 32'd0;
        case (r)
            0: v = {30'd0, m_run[ch], m_to[ch]};
            1: v = {30'd0, m_cont[ch], m_ito[ch]};
            2: v = m_per[ch];
            3: v = m_snap[ch];
            4: v = m_pre[ch];
            5: for (int i = 0; i < NCH; i++) v[i] = m_to[i];
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic bit m_irq();
        bit o;
        o = 1'b0;
        for (int i = 0; i < NCH; i++) o |= m_to[i] & m_ito[i];
        return o;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 32'h0007A11F; m_per[i] = 32'h0007A11F;
            m_pre[i] = 0; m_pc[i] = 0; m_snap[i] = 0;
            m_to[i] = 0; m_run[i] = 0; m_ito[i] = 0; m_cont[i] = 0; m_pulse[i] = 0;
        end
        m_rd = 0;
    endtask

    task automatic m_step();
        int ch, r;
        bit wr, tick, tmo, sel, start;
        ch = int'(addr) >> 3;
        r  = int'(addr) & 7;
        wr = cs && !wn;
        m_rd = (cs && wn) ? m_read(ch, r) : 32'd0;
        for (int i = 0; i < NCH; i++) begin
            sel   = wr && (ch == i);
            start = sel && (r == 1) && wd[2];
            tick  = m_run[i] && (m_pc[i] == 0);
            tmo   = tick && (m_cnt[i] == 0);
            m_pulse[i] = tmo;
            if (sel && r == 3) m_snap[i] = m_cnt[i];
            if (sel && r == 0) m_to[i] = 0;
            if (tmo) m_to[i] = 1;
            if (sel && r == 2) m_cnt[i] = wd;
            else if (tick) m_cnt[i] = (m_cnt[i] == 0) ? m_per[i] : m_cnt[i] - 1;
            if ((sel && r == 2) || start || tick) m_pc[i] = m_pre[i];
            else if (m_run[i]) m_pc[i] = m_pc[i] - 1;
            if (tmo && !m_cont[i]) m_run[i] = 0;
            if (sel && r == 1 && wd[3]) m_run[i] = 0;
            if (start) m_run[i] = 1;
            if (sel && r == 2) m_run[i] = 0;
            if (sel && r == 1) begin m_ito[i] = wd[0]; m_cont[i] = wd[1]; end
            if (sel && r == 2) m_per[i] = wd;
            if (sel && r == 4) m_pre[i] = wd & 32'h0000FFFF;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_reset();
        else          m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_irq", {31'd0, irq}, {31'd0, m_irq()});
            check("cyc_readdata", rdata, m_rd);
`ifdef MULTI_TIMER_PULSE_OUT_EN
            for (int i = 0; i < NCH; i++)
                check("cyc_pulse", {31'd0, tpulse[i]}, {31'd0, m_pulse[i]});
`endif
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_wr(input int ch, input int r, input logic [31:0] d);
        addr = AW'(ch * 8 + r); cs = 1'b1; wn = 1'b0; wd = d;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1; wd = '0;
    endtask

    task automatic bus_rd(input int ch, input int r, output logic [31:0] d);
        addr = AW'(ch * 8 + r); cs = 1'b1; wn = 1'b1;
        @(negedge clk);
        d = rdata; cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_irq(input int bound);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [31:0] v;
    logic [31:0] st [1:22];
    int t0, t1, npulse, r_sel, ch_sel, reg_sel;
    bit irq_seen;
    logic [31:0] d;

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        bus_rd(0, 2, v); check("rst_period", v, 32'h0007A11F);
        bus_rd(0, 0, v); check("rst_status", v, 32'h0);
        bus_rd(0, 4, v); check("rst_prescale", v, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // ch0 periodic with interrupt
        bus_wr(0, 2, 9); bus_wr(0, 1, 7); t0 = cyc;
        wait_irq(40);
        check("irq_first_latency", cyc - t0, 10);
        t1 = cyc;
        bus_wr(0, 0, 0);
        check("irq_drop", {31'd0, irq}, 32'd0);
        wait_irq(40);
        check("irq_interval", cyc - t1, 10);
        bus_wr(0, 1, 8); bus_wr(0, 0, 0);

        // ch1 single-shot with prescale
        bus_wr(1, 2, 3); bus_wr(1, 4, 4); bus_wr(1, 1, 4);
        for (int i = 1; i <= 22; i++) begin
            bus_rd(1, 0, v);
            st[i] = v;
        end
        check("oneshot_running", st[20], 32'h2);
        check("oneshot_to", st[21], 32'h1);
        check("oneshot_stopped", st[22], 32'h1);
        bus_wr(1, 3, 0); bus_rd(1, 3, v); check("oneshot_reload", v, 32'd3);
        bus_rd(0, 5, v); check("pending_ch0", v, 32'h2);
        bus_rd(2, 5, v); check("pending_ch2", v, 32'h2);
        check("irq_ito_off", {31'd0, irq}, 32'd0);

        // clear coincident with timeout
        bus_wr(0, 2, 9); bus_wr(0, 0, 0); bus_wr(0, 1, 7);
        idle(9);
        bus_wr(0, 0, 0);
        bus_rd(0, 0, v); check("to_set_wins", v, 32'h3);

        // snapshot and mid-count PERIOD write
        bus_wr(0, 2, 100); bus_wr(0, 0, 0); bus_wr(0, 1, 6);
        idle(10);
        bus_wr(0, 3, 0);
        bus_rd(0, 3, v); check("snap_value", v, 32'd90);
        bus_wr(0, 2, 50);
        bus_rd(0, 0, v); check("period_wr_stops", v, 32'h0);
        bus_wr(0, 3, 0);
        bus_rd(0, 3, v); check("period_wr_load", v, 32'd50);

`ifdef MULTI_TIMER_PULSE_OUT_EN
        bus_wr(0, 2, 4); bus_wr(0, 0, 0); bus_wr(0, 1, 6);
        npulse = 0; irq_seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (tpulse[0]) npulse++;
            if (irq) irq_seen = 1'b1;
        end
        check("pulse_count", npulse, 5);
        check("pulse_no_irq", {31'd0, irq_seen}, 32'd0);
        bus_wr(0, 1, 8);
`endif

        // asynchronous reset while counting
        bus_wr(0, 2, 9); bus_wr(0, 1, 7);
        idle(12);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(0, 2, v); check("post_reset_period", v, 32'h0007A11F);
        bus_rd(0, 1, v); check("post_reset_control", v, 32'h0);

        // random traffic
        for (int c = 0; c < NCH; c++) begin
            bus_wr(c, 2, 32'($urandom_range(0, 15)));
            bus_wr(c, 4, 32'($urandom_range(0, 3)));
        end
        repeat (4000) begin
            r_sel   = $urandom_range(0, 9);
            ch_sel  = $urandom_range(0, NCH);
            reg_sel = $urandom_range(0, 7);
            if (r_sel < 4) begin
                idle(1);
            end else if (r_sel < 7) begin
                bus_rd(ch_sel, reg_sel, v);
            end else begin
                case (reg_sel)
                    1:       d = 32'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 32'h4 : 32'h0);
                    2:       d = 32'($urandom_range(0, 15));
                    4:       d = 32'($urandom_range(0, 3));
                    default: d = $urandom;
                endcase
                bus_wr(ch_sel, reg_sel, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
